// File: rtl/motion_sequencer_pkg.sv
// motion_sequencer_pkg: motion codes, FSM state type and op validity check
package motion_sequencer_pkg;
  localparam logic [2:0] MOT_FWD     = 3'b000;
  localparam logic [2:0] MOT_RIGHT   = 3'b001;
  localparam logic [2:0] MOT_LEFT    = 3'b010;
  localparam logic [2:0] MOT_STOP    = 3'b011;
  localparam logic [2:0] MOT_TURN180 = 3'b100;
  localparam logic [2:0] MOT_REV     = 3'b101;
  typedef enum logic [1:0] {IDLE, RUN, BRAKE} state_t;
  function automatic logic op_valid(input logic [2:0] op);
    return op <= MOT_REV;
  endfunction
endpackage

// File: rtl/motion_sequencer_tick_prescaler.sv
// tick_prescaler: free-running 0..TICK_DIV-1 counter with tick on the last count
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: timed maneuver sequencer with forced brake interval and abort handling
module motion_sequencer
  import motion_sequencer_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int DUR_W       = 16,
  parameter int BRAKE_TICKS = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             obstacle,
  input  logic             stop_req,
  output logic [2:0]       motor_state,
  output logic             busy,
  output logic             done,
  output logic             done_aborted,
  output logic             err
);
  localparam int BW = BRAKE_TICKS > 1 ? $clog2(BRAKE_TICKS) : 1;
  localparam logic [BW-1:0] BRK_LAST = BW'(BRAKE_TICKS > 0 ? BRAKE_TICKS - 1 : 0);
  state_t state;
  logic [DUR_W-1:0] dur_cnt;
  logic [BW-1:0] brk_cnt;
  logic aborted, tick, accept, abort, expire, clr;
  assign accept = state == IDLE && cmd_valid && cmd_ready && op_valid(cmd_op);
  assign abort  = stop_req || (obstacle && motor_state == MOT_FWD);
  assign expire = tick && dur_cnt == DUR_W'(1);
  // restart the tick phase so RUN and BRAKE last whole multiples of TICK_DIV
  assign clr    = accept || (state == RUN && (abort || expire));
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      motor_state  <= MOT_STOP;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_aborted <= 1'b0;
      err          <= 1'b0;
      dur_cnt      <= '0;
      brk_cnt      <= '0;
      aborted      <= 1'b0;
    end else begin
      done         <= 1'b0;
      done_aborted <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready   <= 1'b1;
          motor_state <= MOT_STOP;
          busy        <= 1'b0;
          if (accept) begin
            state       <= RUN;
            motor_state <= cmd_op;
            dur_cnt     <= cmd_dur;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            aborted     <= 1'b0;
          end else if (cmd_valid && cmd_ready) err <= 1'b1;
        end
        RUN:
          if (abort || expire) begin
            aborted     <= abort;
            motor_state <= MOT_STOP;
            brk_cnt     <= '0;
            if (BRAKE_TICKS == 0) begin
              state        <= IDLE;
              done         <= 1'b1;
              done_aborted <= abort;
              cmd_ready    <= 1'b1;
              busy         <= 1'b0;
            end else state <= BRAKE;
          end else if (tick && dur_cnt != '0) dur_cnt <= dur_cnt - 1'b1;
        BRAKE:
          if (tick) begin
            if (brk_cnt == BRK_LAST) begin
              state        <= IDLE;
              done         <= 1'b1;
              done_aborted <= aborted;
              cmd_ready    <= 1'b1;
              busy         <= 1'b0;
            end else brk_cnt <= brk_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer: directed checks of timing, aborts, back-to-back and reset behaviour
module tb_motion_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, obstacle = 1'b0, stop_req = 1'b0;
  logic [2:0] cmd_op = 3'b000, motor_state;
  logic [15:0] cmd_dur = 16'd0;
  logic busy, done, done_aborted, err;
  int tests = 0, fails = 0;
  motion_sequencer #(.TICK_DIV(4), .DUR_W(16), .BRAKE_TICKS(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dur(cmd_dur), .obstacle(obstacle), .stop_req(stop_req),
    .motor_state(motor_state), .busy(busy), .done(done),
    .done_aborted(done_aborted), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_check(input string tag, input logic [2:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 16'(motor_state), 16'(code));
      chk({tag, "_busy"}, 16'(busy), 16'd1);
      chk({tag, "_nodone"}, 16'(done), 16'd0);
      step();
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [15:0] dur);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_dur = dur;
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic expect_done(input string tag, input logic ab);
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_ab"}, 16'(done_aborted), 16'(ab));
    chk({tag, "_rdy"}, 16'(cmd_ready), 16'd1);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_mot"}, 16'(motor_state), 16'h3);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk("rst_mot", 16'(motor_state), 16'h3);
    chk("rst_rdy", 16'(cmd_ready), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_rdy", 16'(cmd_ready), 16'd1);
    issue(3'b000, 16'd3);
    run_check("fwd3", 3'b000, 12);
    run_check("fwd3_brk", 3'b011, 8);
    expect_done("fwd3", 1'b0);
    step();
    chk("fwd3_pulse", 16'(done), 16'd0);
    issue(3'b110, 16'd5);
    chk("inv_err", 16'(err), 16'd1);
    chk("inv_mot", 16'(motor_state), 16'h3);
    chk("inv_rdy", 16'(cmd_ready), 16'd1);
    chk("inv_busy", 16'(busy), 16'd0);
    step();
    chk("inv_err1", 16'(err), 16'd0);
    chk("inv_busy1", 16'(busy), 16'd0);
    issue(3'b000, 16'd0);
    run_check("cont", 3'b000, 49);
    obstacle = 1'b1;
    chk("cont_c50", 16'(motor_state), 16'h0);
    step();
    obstacle = 1'b0;
    run_check("cont_brk", 3'b011, 8);
    expect_done("cont", 1'b1);
    obstacle = 1'b1;
    issue(3'b100, 16'd2);
    run_check("t180", 3'b100, 8);
    run_check("t180_brk", 3'b011, 8);
    expect_done("t180", 1'b0);
    obstacle = 1'b0;
    issue(3'b100, 16'd2);
    run_check("t180s", 3'b100, 2);
    stop_req = 1'b1;
    chk("t180s_c3", 16'(motor_state), 16'h4);
    step();
    stop_req = 1'b0;
    run_check("t180s_brk", 3'b011, 8);
    expect_done("t180s", 1'b1);
    issue(3'b000, 16'd1);
    run_check("exp_ab", 3'b000, 3);
    obstacle = 1'b1;
    chk("exp_ab_c4", 16'(motor_state), 16'h0);
    step();
    obstacle = 1'b0;
    run_check("exp_ab_brk", 3'b011, 8);
    expect_done("exp_ab", 1'b1);
    cmd_valid = 1'b1;
    cmd_op = 3'b001;
    cmd_dur = 16'd1;
    step();
    cmd_op = 3'b010;
    chk("b2b_rdy", 16'(cmd_ready), 16'd0);
    run_check("b2b_r", 3'b001, 4);
    run_check("b2b_rbrk", 3'b011, 8);
    expect_done("b2b1", 1'b0);
    step();
    cmd_valid = 1'b0;
    run_check("b2b_l", 3'b010, 4);
    run_check("b2b_lbrk", 3'b011, 8);
    expect_done("b2b2", 1'b0);
    issue(3'b101, 16'd5);
    step();
    step();
    chk("mid_mot", 16'(motor_state), 16'h5);
    #2 rst = 1'b1;
    #1;
    chk("async_mot", 16'(motor_state), 16'h3);
    chk("async_rdy", 16'(cmd_ready), 16'd0);
    chk("async_busy", 16'(busy), 16'd0);
    step();
    chk("hold_rdy", 16'(cmd_ready), 16'd0);
    chk("hold_done", 16'(done), 16'd0);
    rst = 1'b0;
    step();
    chk("rel_rdy", 16'(cmd_ready), 16'd1);
    chk("rel_done", 16'(done), 16'd0);
    chk("rel_mot", 16'(motor_state), 16'h3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
- Timed command sequencer that drives the 3-bit motion code consumed by the wheel driver.
- Accepts maneuver commands (op + duration) over a valid/ready handshake and holds each op for an exact number of ticks.
- Inserts a mandatory stop (brake) interval between maneuvers to protect the H-bridge on direction reversal.
- Aborts on obstacle (forward motion only) or on an explicit stop request. Sits between the navigation/CPU command register and the wheel driver.

Parameters:
- TICK_DIV, 100000, clk cycles per motion tick (1 ms at 100 MHz); must be >= 2.
- DUR_W, 16, width of the command duration field.
- BRAKE_TICKS, 50, ticks of stop code (011) forced after every maneuver; 0 skips the brake.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  motion code: 000 fwd, 001 right, 010 left, 011 stop, 100 turn180, 101 reverse
- cmd_dur  in  DUR_W  duration in ticks; 0 = continuous until aborted
- obstacle  in  1  synchronous level: obstacle ahead
- stop_req  in  1  synchronous level: abort current maneuver
- motor_state  out  3  registered code to the wheel driver
- busy  out  1  high in RUN or BRAKE
- done  out  1  one-cycle pulse when a maneuver (including its brake) completes
- done_aborted  out  1  valid with done: maneuver ended by abort
- err  out  1  one-cycle pulse: invalid op (110/111) offered

Behaviour:
- Reset (async): FSM=IDLE, motor_state=011, cmd_ready=0 while rst high, busy/done/done_aborted/err=0, counters=0.
- FSM states: IDLE, RUN, BRAKE. All outputs are registered.
- IDLE:
  - cmd_ready=1, motor_state=011.
  - Accept when cmd_valid&&cmd_ready at edge k and op is valid. From cycle k+1: RUN, motor_state=op, dur_cnt=cmd_dur, prescaler cleared.
  - Invalid op: err=1 for cycle k+1, stay IDLE, cmd_ready stays 1.
  - op=011 is accepted and runs like any other op, outputting 011.
- Prescaler:
  - Counts 0..TICK_DIV-1 and asserts tick at TICK_DIV-1.
  - Cleared on accept and on BRAKE entry, so RUN lasts exactly cmd_dur*TICK_DIV cycles and BRAKE lasts BRAKE_TICKS*TICK_DIV cycles.
- RUN:
  - cmd_ready=0, busy=1.
  - On tick, dur_cnt decrements. When tick arrives with dur_cnt==1, go to BRAKE.
  - cmd_dur==0: never expires.
- Abort (evaluated in RUN only):
  - Triggered by stop_req=1, or obstacle=1 with op==000.
  - Next cycle: BRAKE with motor_state=011 and the aborted flag set.
  - Abort in the same cycle as expiry counts as an abort.
  - obstacle is ignored for ops other than 000, so the robot can back away or turn.
- BRAKE:
  - motor_state=011, busy=1.
  - After BRAKE_TICKS ticks, go to IDLE. done=1 and done_aborted=flag in the first IDLE cycle, with cmd_ready=1 in that same cycle.
  - stop_req and obstacle are ignored.
  - BRAKE_TICKS=0: RUN goes directly to IDLE and done is asserted with motor_state=011.
- Back-to-back: a command accepted in the done cycle starts RUN on the next cycle. No gap beyond the brake.
- cmd_valid held while cmd_ready=0 is not consumed. cmd_op/cmd_dur are captured only at acceptance.
- Reset mid-operation: immediate 011 and IDLE. No done pulse.

Decomposition:
- Shared package:
  - Motion code constants: MOT_FWD=000, MOT_RIGHT=001, MOT_LEFT=010, MOT_STOP=011, MOT_TURN180=100, MOT_REV=101.
  - FSM state typedef {IDLE, RUN, BRAKE}.
  - The op validity function.
- One sub-module: tick_prescaler (parameter TICK_DIV; ports clk, rst, clr, tick).

Test Plan:
- Timed forward, no abort. TICK_DIV=4, BRAKE_TICKS=2; accept fwd dur=3 at edge 0.
  -> motor_state=000 cycles 1–12, 011 cycles 13–20; done=1 with done_aborted=0 and cmd_ready=1 at cycle 21.
- Invalid op. Offer op=110 in IDLE -> err=1 for exactly one cycle; motor_state stays 011; cmd_ready stays 1; no busy.
- Continuous forward with obstacle. Fwd dur=0; obstacle=1 at cycle 50.
  -> motor_state=011 from cycle 51; done with done_aborted=1 after 8 brake cycles.
- Obstacle does not abort turn180. Turn180 (100) dur=2 with obstacle held high.
  -> 100 for 8 cycles, then brake; done_aborted=0. Same test with stop_req pulsed in RUN -> aborted=1.
- Back-to-back commands. cmd_valid held high with left dur=1 queued during a right dur=1 maneuver.
  -> left accepted in the done cycle; sequence 001×4, 011×8, 010×4, 011×8; two done pulses.
- Reset mid-RUN. Assert rst asynchronously during RUN.
  -> motor_state=011 before the next clk edge; cmd_ready=0 while rst is high; no done pulse; cmd_ready=1 after release.
